// File: rtl/rv32m_div_unit_if.sv
// Execute-side request and write-back request signals of the RV32M divider.
// The master side is execute plus the write-back arbiter; the slave side is the divider.
interface rv32m_div_unit_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  rs1_val;
    logic [WIDTH-1:0]  rs2_val;
    logic [ADDR_W-1:0] rd_addr;
    logic              flush;
    logic              busy;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              wb_ack;

    modport master (
        output start, op, rs1_val, rs2_val, rd_addr, flush, wb_ack,
        input  busy, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd_addr, flush, wb_ack,
        output busy, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/rv32m_div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// The result is held on the write-back request port until the arbiter acknowledges it.
module rv32m_div_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    rv32m_div_unit_if.slave dif
);
    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quot_q;
    logic [WIDTH-1:0]  dvsr_q;
    logic [WIDTH-1:0]  wb_data_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic              sel_rem_q;
    logic              q_neg_q;
    logic              r_neg_q;

    logic              signed_op;
    logic              accept;
    logic              div_zero;
    logic              overflow;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH-1:0]  diff;
    logic [WIDTH-1:0]  rem_nxt;
    logic [WIDTH-1:0]  quot_nxt;
    logic              no_borrow;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] n;
        n = -v;
        return v[WIDTH-1] ? n : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    // Writes to x0 are dropped at the door so the unit never goes busy for them.
    assign signed_op = ~dif.op[0];
    assign accept    = (state_q == IDLE) && dif.start && !dif.flush && (dif.rd_addr != '0);
    assign div_zero  = (dif.rs2_val == '0);
    assign overflow  = signed_op && (dif.rs1_val == MIN_NEG) && (dif.rs2_val == '1);

    // The remainder gains one bit per step, so the trial subtract needs WIDTH+1 bits.
    assign rem_sh    = {rem_q, quot_q[WIDTH-1]};
    assign no_borrow = (rem_sh >= {1'b0, dvsr_q});
    assign diff      = rem_sh[WIDTH-1:0] - dvsr_q;
    assign rem_nxt   = no_borrow ? diff : rem_sh[WIDTH-1:0];
    assign quot_nxt  = {quot_q[WIDTH-2:0], no_borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (div_zero || overflow) ? DONE : CALC;
            CALC: begin
                if (dif.flush)                   state_d = IDLE;
                else if (count_q == LAST_STEP)   state_d = DONE;
            end
            DONE: if (dif.flush || dif.wb_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            dvsr_q    <= '0;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            sel_rem_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wb_addr_q <= dif.rd_addr;
                        sel_rem_q <= dif.op[1];
                        if (div_zero) begin
                            wb_data_q <= dif.op[1] ? dif.rs1_val : '1;
                        end else if (overflow) begin
                            wb_data_q <= dif.op[1] ? '0 : MIN_NEG;
                        end else begin
                            count_q <= '0;
                            rem_q   <= '0;
                            quot_q  <= signed_op ? magnitude(dif.rs1_val) : dif.rs1_val;
                            dvsr_q  <= signed_op ? magnitude(dif.rs2_val) : dif.rs2_val;
                            q_neg_q <= signed_op && (dif.rs1_val[WIDTH-1] ^ dif.rs2_val[WIDTH-1]);
                            r_neg_q <= signed_op && dif.rs1_val[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    rem_q   <= rem_nxt;
                    quot_q  <= quot_nxt;
                    count_q <= count_q + 1'b1;
                    // Signs are restored on the way into DONE so wb_data is final when wb_en rises.
                    if (count_q == LAST_STEP) begin
                        wb_data_q <= sel_rem_q ? apply_sign(rem_nxt, r_neg_q)
                                               : apply_sign(quot_nxt, q_neg_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dif.busy    = (state_q != IDLE);
    assign dif.wb_en   = (state_q == DONE);
    assign dif.wb_addr = wb_addr_q;
    assign dif.wb_data = wb_data_q;
endmodule
